// File: rtl/draw_tri_sequencer.sv
`timescale 1ns/1ps
// Triangle command sequencer: queues commands, y-sorts vertices, starts
// the fill engine and turns its pixels into clipped VRAM write requests.
// Ports: cmd_* (valid/ready command in), eng_* (fill engine control/status),
// wr_* (req/ack VRAM write), busy_o/done_o (status).
module draw_tri_sequencer #(
  parameter int CORDW = 16,
  parameter int DEPTH = 4,
  parameter int ADDRW = 16
) (
  input  logic                    clk,
  input  logic                    reset_n_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic signed [CORDW-1:0] cmd_x0_i,
  input  logic signed [CORDW-1:0] cmd_y0_i,
  input  logic signed [CORDW-1:0] cmd_x1_i,
  input  logic signed [CORDW-1:0] cmd_y1_i,
  input  logic signed [CORDW-1:0] cmd_x2_i,
  input  logic signed [CORDW-1:0] cmd_y2_i,
  input  logic [15:0]             cmd_color_i,
  input  logic [ADDRW-1:0]        base_addr_i,
  input  logic [ADDRW-1:0]        pitch_i,
  input  logic signed [CORDW-1:0] clip_w_i,
  input  logic signed [CORDW-1:0] clip_h_i,
  output logic                    eng_start_o,
  output logic                    eng_oe_o,
  output logic signed [CORDW-1:0] eng_x0_o,
  output logic signed [CORDW-1:0] eng_y0_o,
  output logic signed [CORDW-1:0] eng_x1_o,
  output logic signed [CORDW-1:0] eng_y1_o,
  output logic signed [CORDW-1:0] eng_x2_o,
  output logic signed [CORDW-1:0] eng_y2_o,
  input  logic signed [CORDW-1:0] eng_x_i,
  input  logic signed [CORDW-1:0] eng_y_i,
  input  logic                    eng_drawing_i,
  input  logic                    eng_busy_i,
  input  logic                    eng_done_i,
  output logic                    wr_req_o,
  input  logic                    wr_ack_i,
  output logic [ADDRW-1:0]        wr_addr_o,
  output logic [15:0]             wr_data_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ONE = 1;

  typedef struct packed {
    logic signed [CORDW-1:0] x0, y0, x1, y1, x2, y2;
    logic [15:0]             col;
    logic [ADDRW-1:0]        base, pitch;
    logic signed [CORDW-1:0] cw, ch;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE, S_SORT0, S_SORT1, S_SORT2, S_START, S_DRAW, S_DRAIN
  } state_t;

  cmd_t       r_mem [DEPTH];
  logic [PW:0] r_wp, r_rp;
  state_t     r_state, w_next;

  logic signed [CORDW-1:0] r_x0, r_y0, r_x1, r_y1, r_x2, r_y2;
  logic signed [CORDW-1:0] r_cw, r_ch;
  logic [15:0]             r_col;
  logic [ADDRW-1:0]        r_base, r_pitch;

  logic             r_wr_req;
  logic [ADDRW-1:0] r_wr_addr;
  logic [15:0]      r_wr_data;

  cmd_t w_in, w_head;
  logic w_full, w_empty, w_push, w_pop;
  logic w_start, w_oe, w_done;
  logic w_clip, w_fire;
  logic [ADDRW+CORDW-1:0] w_sum;
  logic w_unused;

  // Extra pointer bit distinguishes full from empty.
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[PW] != r_rp[PW]) &&
                   (r_wp[PW-1:0] == r_rp[PW-1:0]);
  assign w_push  = cmd_valid_i && cmd_ready_o;
  assign w_head  = r_mem[r_rp[PW-1:0]];

  assign w_in = '{x0: cmd_x0_i, y0: cmd_y0_i,
                  x1: cmd_x1_i, y1: cmd_y1_i,
                  x2: cmd_x2_i, y2: cmd_y2_i,
                  col: cmd_color_i, base: base_addr_i,
                  pitch: pitch_i, cw: clip_w_i, ch: clip_h_i};

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp[PW-1:0]] <= w_in;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + ONE;
      if (w_pop)  r_rp <= r_rp + ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_pop   = 1'b0;
    w_start = 1'b0;
    w_oe    = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: if (!w_empty) begin
        w_pop  = 1'b1;
        w_next = S_SORT0;
      end
      S_SORT0: w_next = S_SORT1;
      S_SORT1: w_next = S_SORT2;
      S_SORT2: w_next = S_START;
      S_START: begin
        w_start = 1'b1;
        w_next  = S_DRAW;
      end
      S_DRAW: begin
        w_oe = !r_wr_req || wr_ack_i;
        if (eng_done_i) w_next = S_DRAIN;
      end
      S_DRAIN: if (!r_wr_req) begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Bubble network; strict compare keeps ties in command order.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_x0 <= '0; r_y0 <= '0;
      r_x1 <= '0; r_y1 <= '0;
      r_x2 <= '0; r_y2 <= '0;
      r_cw <= '0; r_ch <= '0;
      r_col <= '0; r_base <= '0; r_pitch <= '0;
    end else if (w_pop) begin
      r_x0 <= w_head.x0; r_y0 <= w_head.y0;
      r_x1 <= w_head.x1; r_y1 <= w_head.y1;
      r_x2 <= w_head.x2; r_y2 <= w_head.y2;
      r_cw <= w_head.cw; r_ch <= w_head.ch;
      r_col   <= w_head.col;
      r_base  <= w_head.base;
      r_pitch <= w_head.pitch;
    end else begin
      unique case (1'b1)
        (r_state == S_SORT0) && (r_y0 > r_y1),
        (r_state == S_SORT2) && (r_y0 > r_y1): begin
          r_x0 <= r_x1; r_y0 <= r_y1;
          r_x1 <= r_x0; r_y1 <= r_y0;
        end
        (r_state == S_SORT1) && (r_y1 > r_y2): begin
          r_x1 <= r_x2; r_y1 <= r_y2;
          r_x2 <= r_x1; r_y2 <= r_y1;
        end
        default: ;
      endcase
    end
  end

  assign w_clip = eng_x_i[CORDW-1] || eng_y_i[CORDW-1] ||
                  (eng_x_i >= r_cw) || (eng_y_i >= r_ch);
  assign w_fire = eng_drawing_i && w_oe && !w_clip;

  // Coordinates are non-negative once unclipped, so zero-extend.
  assign w_sum = {{CORDW{1'b0}}, r_base}
               + ({{ADDRW{1'b0}}, eng_y_i} * {{CORDW{1'b0}}, r_pitch})
               + {{ADDRW{1'b0}}, eng_x_i};

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_req  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_fire) begin
      r_wr_req  <= 1'b1;
      r_wr_addr <= w_sum[ADDRW-1:0];
      r_wr_data <= r_col;
    end else if (wr_ack_i) begin
      r_wr_req <= 1'b0;
    end
  end

  assign w_unused = ^{eng_busy_i, w_sum[ADDRW+CORDW-1:ADDRW]};

  assign cmd_ready_o = reset_n_i && !w_full;
  assign eng_start_o = w_start;
  assign eng_oe_o    = w_oe;
  assign eng_x0_o    = r_x0;
  assign eng_y0_o    = r_y0;
  assign eng_x1_o    = r_x1;
  assign eng_y1_o    = r_y1;
  assign eng_x2_o    = r_x2;
  assign eng_y2_o    = r_y2;
  assign wr_req_o    = r_wr_req;
  assign wr_addr_o   = r_wr_addr;
  assign wr_data_o   = r_wr_data;
  assign busy_o      = !w_empty || (r_state != S_IDLE) || r_wr_req;
  assign done_o      = w_done;

endmodule

// File: tb/tb_draw_tri_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for draw_tri_sequencer with a bounding-box
// fill engine model and a write-address scoreboard.
module tb_draw_tri_sequencer;
  localparam int CW = 16;
  localparam int AW = 16;

  logic clk = 0;
  logic reset_n_i = 0;
  always #5 clk = ~clk;

  logic cmd_valid_i = 0;
  logic cmd_ready_o;
  logic signed [CW-1:0] cmd_x0_i = 0, cmd_y0_i = 0, cmd_x1_i = 0;
  logic signed [CW-1:0] cmd_y1_i = 0, cmd_x2_i = 0, cmd_y2_i = 0;
  logic [15:0] cmd_color_i = 0;
  logic [AW-1:0] base_addr_i = 0, pitch_i = 0;
  logic signed [CW-1:0] clip_w_i = 0, clip_h_i = 0;
  logic eng_start_o, eng_oe_o;
  logic signed [CW-1:0] eng_x0_o, eng_y0_o, eng_x1_o;
  logic signed [CW-1:0] eng_y1_o, eng_x2_o, eng_y2_o;
  logic signed [CW-1:0] eng_x_i = 0, eng_y_i = 0;
  logic eng_drawing_i = 0, eng_busy_i = 0, eng_done_i = 0;
  logic wr_req_o, wr_ack_i = 1;
  logic [AW-1:0] wr_addr_o;
  logic [15:0] wr_data_o;
  logic busy_o, done_o;

  draw_tri_sequencer #(.CORDW(CW), .DEPTH(4), .ADDRW(AW)) dut (
    .clk(clk), .reset_n_i(reset_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_x0_i(cmd_x0_i), .cmd_y0_i(cmd_y0_i),
    .cmd_x1_i(cmd_x1_i), .cmd_y1_i(cmd_y1_i),
    .cmd_x2_i(cmd_x2_i), .cmd_y2_i(cmd_y2_i),
    .cmd_color_i(cmd_color_i), .base_addr_i(base_addr_i),
    .pitch_i(pitch_i), .clip_w_i(clip_w_i), .clip_h_i(clip_h_i),
    .eng_start_o(eng_start_o), .eng_oe_o(eng_oe_o),
    .eng_x0_o(eng_x0_o), .eng_y0_o(eng_y0_o),
    .eng_x1_o(eng_x1_o), .eng_y1_o(eng_y1_o),
    .eng_x2_o(eng_x2_o), .eng_y2_o(eng_y2_o),
    .eng_x_i(eng_x_i), .eng_y_i(eng_y_i),
    .eng_drawing_i(eng_drawing_i), .eng_busy_i(eng_busy_i),
    .eng_done_i(eng_done_i),
    .wr_req_o(wr_req_o), .wr_ack_i(wr_ack_i),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  typedef struct packed {
    int x0, y0, x1, y1, x2, y2;
    int col, base, pitch, cw, ch, acc, lat;
  } cmd_t;

  int errors = 0, checks = 0;
  int cyc = 0, acc_cnt = 0, done_cnt = 0, wr_cnt = 0;
  int first_addr = -1, hold_chk = 0, ack_mode = 0;
  cmd_t drv, cur;
  cmd_t cmdq[$];
  int expa[$], expd[$];
  bit cur_v = 0, eng_adv = 0, start_seen = 0, hold_v = 0, eact = 0;
  int sv[6];
  int hold_a, hold_d;
  int ex, ey, xmin, xmax, ymin, ymax;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk(int x0, int y0, int x1, int y1, int x2,
                              int y2, int col, int base, int pitch,
                              int cw, int ch, int lat);
    cmd_t c;
    c.x0 = x0; c.y0 = y0; c.x1 = x1; c.y1 = y1; c.x2 = x2; c.y2 = y2;
    c.col = col; c.base = base; c.pitch = pitch;
    c.cw = cw; c.ch = ch; c.acc = 0; c.lat = lat;
    return c;
  endfunction

  // Monitor / scoreboard: samples pre-edge values at posedge.
  always @(posedge clk) begin
    int xs[3], ys[3], px, py, t;
    cmd_t c;
    if (reset_n_i) begin
      cyc++;
      eng_adv = eng_drawing_i && eng_oe_o;
      if (cmd_valid_i && cmd_ready_o) begin
        c = drv; c.acc = cyc;
        cmdq.push_back(c);
        acc_cnt++;
      end
      if (eng_start_o) begin
        start_seen = 1;
        sv[0] = int'(eng_x0_o); sv[1] = int'(eng_y0_o);
        sv[2] = int'(eng_x1_o); sv[3] = int'(eng_y1_o);
        sv[4] = int'(eng_x2_o); sv[5] = int'(eng_y2_o);
        if (cmdq.size() == 0) check("start_unexpected", 1, 0);
        else begin
          cur = cmdq.pop_front(); cur_v = 1;
          xs[0] = cur.x0; xs[1] = cur.x1; xs[2] = cur.x2;
          ys[0] = cur.y0; ys[1] = cur.y1; ys[2] = cur.y2;
          for (int i = 1; i < 3; i++)
            for (int j = i; j > 0 && ys[j-1] > ys[j]; j--) begin
              t = ys[j]; ys[j] = ys[j-1]; ys[j-1] = t;
              t = xs[j]; xs[j] = xs[j-1]; xs[j-1] = t;
            end
          check("sort_x0", sv[0], xs[0]); check("sort_y0", sv[1], ys[0]);
          check("sort_x1", sv[2], xs[1]); check("sort_y1", sv[3], ys[1]);
          check("sort_x2", sv[4], xs[2]); check("sort_y2", sv[5], ys[2]);
          if (cur.lat != 0) check("start_latency", cyc - cur.acc, 5);
          wr_cnt = 0; first_addr = -1;
        end
      end
      if (eng_adv && cur_v) begin
        px = int'(eng_x_i); py = int'(eng_y_i);
        if (!(px < 0 || py < 0 || px >= cur.cw || py >= cur.ch)) begin
          expa.push_back((cur.base + py * cur.pitch + px) & 'hFFFF);
          expd.push_back(cur.col);
        end
      end
      if (hold_v && wr_req_o) begin
        hold_chk++;
        check("hold_addr", int'(wr_addr_o), hold_a);
        check("hold_data", int'(wr_data_o), hold_d);
      end
      if (wr_req_o && !wr_ack_i) check("oe_stall", int'(eng_oe_o), 0);
      hold_v = wr_req_o && !wr_ack_i;
      hold_a = int'(wr_addr_o); hold_d = int'(wr_data_o);
      if (wr_req_o && wr_ack_i) begin
        if (expa.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          check("wr_addr", int'(wr_addr_o), expa.pop_front());
          check("wr_data", int'(wr_data_o), expd.pop_front());
        end
        if (first_addr < 0) first_addr = int'(wr_addr_o);
        wr_cnt++;
      end
      if (done_o) done_cnt++;
    end
  end

  // Fill engine model: walks the bounding box of the sorted vertices.
  always @(negedge clk) begin
    if (reset_n_i) begin
      eng_done_i = 0;
      if (start_seen) begin
        xmin = sv[0]; xmax = sv[0];
        for (int i = 1; i < 3; i++) begin
          if (sv[2*i] < xmin) xmin = sv[2*i];
          if (sv[2*i] > xmax) xmax = sv[2*i];
        end
        ymin = sv[1]; ymax = sv[5];
        ex = xmin; ey = ymin; eact = 1;
        eng_drawing_i = 1; eng_busy_i = 1;
        start_seen = 0;
      end else if (eact && eng_adv) begin
        if (ex < xmax) ex++;
        else if (ey < ymax) begin ex = xmin; ey++; end
        else begin
          eact = 0; eng_drawing_i = 0; eng_busy_i = 0; eng_done_i = 1;
        end
      end
      eng_adv = 0;
      eng_x_i = CW'(ex); eng_y_i = CW'(ey);
      wr_ack_i = (ack_mode == 0) || (cyc % 3 == 0);
    end
  end

  task automatic send(input cmd_t c);
    int n0, t;
    n0 = acc_cnt; t = 0;
    drv = c;
    cmd_x0_i = CW'(c.x0); cmd_y0_i = CW'(c.y0);
    cmd_x1_i = CW'(c.x1); cmd_y1_i = CW'(c.y1);
    cmd_x2_i = CW'(c.x2); cmd_y2_i = CW'(c.y2);
    cmd_color_i = 16'(c.col); base_addr_i = AW'(c.base);
    pitch_i = AW'(c.pitch);
    clip_w_i = CW'(c.cw); clip_h_i = CW'(c.ch);
    cmd_valid_i = 1;
    do begin @(negedge clk); t++; end while (acc_cnt == n0 && t < 400);
    cmd_valid_i = 0;
    if (acc_cnt == n0) check("send_timeout", 0, 1);
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 2000) begin @(negedge clk); t++; end
    check("done_count", done_cnt, target);
  endtask

  initial begin
    int d0, t;
    repeat (2) @(negedge clk);
    check("rst_wr_req", int'(wr_req_o), 0);
    check("rst_start", int'(eng_start_o), 0);
    check("rst_oe", int'(eng_oe_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_ready", int'(cmd_ready_o), 0);
    reset_n_i = 1;
    @(negedge clk);
    check("ready_after_rst", int'(cmd_ready_o), 1);

    send(mk(0, 0, 4, 0, 0, 4, 'hF00F, 'h1000, 320, 320, 240, 1));
    wait_done(1);
    check("t1_writes", wr_cnt, 25);
    check("t1_first_addr", first_addr, 'h1000);
    repeat (3) @(negedge clk);
    check("t1_single_done", done_cnt, 1);

    send(mk(0, 9, 5, 2, 3, 2, 'h1234, 0, 16, 64, 64, 1));
    wait_done(2);
    check("t2_x0", sv[0], 5); check("t2_x1", sv[2], 3);
    check("t2_y1", sv[3], 2); check("t2_y2", sv[5], 9);
    check("t2_writes", wr_cnt, 48);

    send(mk(-3, -3, 5, -3, -3, 5, 'hABCD, 'h2000, 4, 4, 4, 1));
    wait_done(3);
    check("t3_writes", wr_cnt, 16);
    check("t3_first_addr", first_addr, 'h2000);

    ack_mode = 1;
    send(mk(0, 0, 4, 0, 0, 4, 'hF00F, 'h1000, 320, 320, 240, 1));
    wait_done(4);
    check("t4_writes", wr_cnt, 25);
    check("t4_hold_seen", int'(hold_chk > 0), 1);
    ack_mode = 0;

    send(mk(0, 0, 4, 0, 0, 4, 'h0001, 'h100, 8, 16, 16, 0));
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++)
      send(mk(k, 1, k + 1, 2, k, 3, 'h10 + k, 'h200, 8, 16, 16, 0));
    check("t5_ready_full", int'(cmd_ready_o), 0);
    check("t5_busy", int'(busy_o), 1);
    wait_done(9);
    check("t5_busy_fall", int'(busy_o), 0);
    check("t5_queue_empty", cmdq.size(), 0);

    ack_mode = 1;
    send(mk(0, 0, 9, 0, 0, 9, 'h5555, 0, 32, 64, 64, 0));
    send(mk(1, 1, 2, 1, 1, 2, 'h6666, 0, 32, 64, 64, 0));
    send(mk(2, 2, 3, 2, 2, 3, 'h7777, 0, 32, 64, 64, 0));
    t = 0;
    while (!eng_drawing_i && t < 100) begin @(negedge clk); t++; end
    check("t6_drawing", int'(eng_drawing_i), 1);
    repeat (10) @(negedge clk);
    d0 = done_cnt;
    #2 reset_n_i = 0;
    #1;
    check("t6_rst_wr_req", int'(wr_req_o), 0);
    check("t6_rst_oe", int'(eng_oe_o), 0);
    check("t6_rst_busy", int'(busy_o), 0);
    check("t6_rst_done", int'(done_o), 0);
    check("t6_rst_start", int'(eng_start_o), 0);
    cmdq.delete(); expa.delete(); expd.delete();
    cur_v = 0; hold_v = 0; eact = 0; start_seen = 0; eng_adv = 0;
    eng_drawing_i = 0; eng_busy_i = 0; eng_done_i = 0;
    ack_mode = 0;
    @(negedge clk);
    reset_n_i = 1;
    repeat (20) @(negedge clk);
    check("t6_no_done", done_cnt, d0);
    check("t6_idle_empty", int'(busy_o), 0);
    check("t6_no_wr", int'(wr_req_o), 0);
    send(mk(0, 0, 2, 0, 0, 2, 'h9999, 'h300, 10, 64, 64, 1));
    wait_done(d0 + 1);
    check("t6_writes", wr_cnt, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
